bcd_to_binary: RTL and testbench

Sequential BCD-to-binary converter, the inverse of the saturating 0–100 up/down counter's BCD digit outputs. It accepts three BCD digits (hundreds, tens, units) on a start strobe and validates them against the 0–100 range. It then produces the 7-bit binary value using a 7-iteration reverse double-dabble (shift-right / subtract-3) loop. It sits between digit-entry logic and any block that needs to preload a 0–100 count.

---
 rtl/bcd_to_binary.sv | 83 ++++++++
 tb/tb_bcd_to_binary.sv | 135 +++++++++++++
 2 files changed

// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential 3-digit BCD (0..100) to 7-bit binary converter using reverse double-dabble
module bcd_to_binary (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [3:0] hundreds_i,
    input  logic [3:0] tens_i,
    input  logic [3:0] units_i,
    output logic [6:0] value_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [18:0] work_q, work_d;
    logic [6:0]  value_q;
    logic        busy_q, done_q, error_q, valid;
    logic [18:0] sh;
    function automatic logic [3:0] fix(input logic [3:0] n);
        return n >= 4'd8 ? n - 4'd3 : n;
    endfunction
    // one reverse double-dabble step: shift right, then correct each BCD nibble independently
    always_comb begin
        sh     = {1'b0, work_q[18:1]};
        work_d = {fix(sh[18:15]), fix(sh[14:11]), fix(sh[10:7]), sh[6:0]};
    end
    // only 0..100 with every digit in 0..9 is accepted
    always_comb begin
        valid = hundreds_i <= 4'd1 && tens_i <= 4'd9 && units_i <= 4'd9 &&
                (hundreds_i == 4'd0 || (tens_i == 4'd0 && units_i == 4'd0));
    end
    // control FSM with registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            value_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        if (valid) begin
                            work_q  <= {hundreds_i, tens_i, units_i, 7'd0};
                            cnt_q   <= '0;
                            error_q <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= SHIFT;
                        end else begin
                            error_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q + 3'd1;
                    if (cnt_q == 3'd6) begin
                        value_q <= work_d[6:0];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
    assign value_o = value_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign error_o = error_q;
endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary: directed and randomized checks of bcd_to_binary against an arithmetic model
module tb_bcd_to_binary;
    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b1;
    logic       start_i = 1'b0;
    logic [3:0] hundreds_i = '0, tens_i = '0, units_i = '0;
    logic [6:0] value_o;
    logic       busy_o, done_o, error_o;
    int         passed = 0, failed = 0, total = 0;
    logic [6:0] exp_val = '0;
    logic       exp_err = 1'b0;

    always #5 clk_i = ~clk_i;

    bcd_to_binary dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .hundreds_i(hundreds_i), .tens_i(tens_i), .units_i(units_i),
        .value_o(value_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_val"}, value_o, exp_val);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_err"}, error_o, exp_err);
    endtask

    // one request; model: accepted iff all digits <= 9 and the decimal number <= 100
    task automatic req(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u, input bit interfere);
        int  n;
        bit  ok;
        n  = int'(h) * 100 + int'(t) * 10 + int'(u);
        ok = h <= 9 && t <= 9 && u <= 9 && n <= 100;
        @(negedge clk_i);
        hundreds_i = h; tens_i = t; units_i = u; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        hundreds_i = 4'($urandom); tens_i = 4'($urandom); units_i = 4'($urandom);
        if (!ok) begin
            exp_err = 1'b1;
            check("inv_done", done_o, 1);
            check("inv_err", error_o, 1);
            check("inv_busy", busy_o, 0);
            check("inv_val", value_o, exp_val);
            @(negedge clk_i);
            check("inv_done_clr", done_o, 0);
            check("inv_err_hold", error_o, 1);
            check("inv_busy2", busy_o, 0);
        end else begin
            exp_err = 1'b0;
            check("acc_busy", busy_o, 1);
            check("acc_done", done_o, 0);
            check("acc_err", error_o, 0);
            for (int k = 1; k <= 6; k++) begin
                if (interfere && k <= 5) begin
                    start_i = 1'b1; hundreds_i = 4'd0; tens_i = 4'd9; units_i = 4'd9;
                end else start_i = 1'b0;
                @(negedge clk_i);
                check("shift_busy", busy_o, 1);
                check("shift_done", done_o, 0);
            end
            start_i = 1'b0;
            exp_val = 7'(n);
            @(negedge clk_i);
            check("fin_done", done_o, 1);
            check("fin_busy", busy_o, 0);
            check("fin_val", value_o, exp_val);
            check("fin_err", error_o, 0);
            @(negedge clk_i);
            check_idle_outputs("post");
            if (interfere) begin
                @(negedge clk_i);
                check_idle_outputs("no_restart");
            end
        end
    endtask

    initial begin
        #2 rst_ni = 1'b0;
        #1 check_idle_outputs("reset");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        req(4'd1, 4'd0, 4'd0, 1'b0);
        req(4'd0, 4'd5, 4'd7, 1'b0);
        req(4'd0, 4'd0, 4'd0, 1'b0);
        req(4'd0, 4'd5, 4'd7, 1'b0);
        req(4'd0, 4'hA, 4'd0, 1'b0);
        req(4'd0, 4'd0, 4'd9, 1'b0);
        req(4'd1, 4'd0, 4'd1, 1'b0);
        req(4'd2, 4'd0, 4'd0, 1'b0);
        req(4'd0, 4'd4, 4'd2, 1'b1);
        // asynchronous reset during the fourth SHIFT cycle
        @(negedge clk_i);
        hundreds_i = 4'd0; tens_i = 4'd8; units_i = 4'd8; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("pre_rst_busy", busy_o, 1);
        #1 rst_ni = 1'b0;
        exp_val = '0;
        exp_err = 1'b0;
        #1 check_idle_outputs("abort");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (10) begin
            @(negedge clk_i);
            check("abort_no_done", done_o, 0);
        end
        req(4'd0, 4'd8, 4'd8, 1'b0);
        for (int i = 0; i < 24; i++) begin
            logic [3:0] h, t, u;
            if ($urandom_range(0, 1) == 1) begin
                int n;
                n = $urandom_range(0, 100);
                h = 4'(n / 100); t = 4'((n / 10) % 10); u = 4'(n % 10);
            end else begin
                h = 4'($urandom_range(0, 2)); t = 4'($urandom); u = 4'($urandom);
            end
            req(h, t, u, 1'($urandom_range(0, 1)));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
